clk_tick_frac: RTL

CLK_TICK_FRAC -- requirements
Module: clk_tick_frac

---
 rtl/clk_tick_frac_if.sv | 29 ++
 rtl/clk_tick_frac.sv | 116 +++++++++++
 2 files changed

// File: rtl/clk_tick_frac_if.sv
// Bus bundle for the fractional tick generator.
// The master side drives control and increment writes.
// The slave side returns the tick, overflow, capture and state outputs.
interface clk_tick_frac_if #(
    parameter int CCntW = 32
);
    logic             AClkHEn;
    logic             ACascadeI;
    logic             ARun;
    logic             AIncWr;
    logic [15:0]      AIncData;
    logic             AClrCnt;
    logic             ACapReq;
    logic             ATick;
    logic             AOvf;
    logic             ACapVld;
    logic [CCntW-1:0] ACapData;
    logic [1:0]       AState;

    modport master (
        output AClkHEn, ACascadeI, ARun, AIncWr, AIncData, AClrCnt, ACapReq,
        input  ATick, AOvf, ACapVld, ACapData, AState
    );

    modport slave (
        input  AClkHEn, ACascadeI, ARun, AIncWr, AIncData, AClrCnt, ACapReq,
        output ATick, AOvf, ACapVld, ACapData, AState
    );
endinterface

// File: rtl/clk_tick_frac.sv
// Fractional tick generator.
// A 16-bit phase accumulator advances by the programmable increment on every
// cascade event. Each carry out of the accumulator becomes a one-cycle tick.
// The ticks are counted in a wrapping counter that can be cleared and captured.
module clk_tick_frac #(
    parameter logic [15:0] CIncReset = 16'h8000,
    parameter int          CCntW     = 32
) (
    input logic            AClkH,
    input logic            AResetH,
    clk_tick_frac_if.slave ABus
);

    typedef enum logic [1:0] {
        SIdle = 2'd0,
        SArm  = 2'd1,
        SRun  = 2'd2
    } StateT;

    localparam logic [CCntW-1:0] CCntOne = {{(CCntW-1){1'b0}}, 1'b1};

    StateT            fState;
    StateT            stateNext;
    logic [15:0]      fAcc;
    logic [15:0]      fInc;
    logic [15:0]      accNext;
    logic [15:0]      addend;
    logic [16:0]      phaseSum;
    logic [CCntW-1:0] fCnt;
    logic [CCntW-1:0] cntNext;
    logic [CCntW-1:0] fCapData;
    logic             fTick;
    logic             fOvf;
    logic             fCapVld;
    logic             isEvent;
    logic             accActive;
    logic             tickNext;
    logic             ovfNext;

    assign isEvent = ABus.AClkHEn & ABus.ACascadeI;

    // Next state: dropping ARun returns to idle from anywhere; arming waits for the first event.
    always_comb begin
        stateNext = fState;
        case (fState)
            SIdle:   if (ABus.ARun) stateNext = SArm;
            SArm:    if (!ABus.ARun) stateNext = SIdle;
                     else if (isEvent) stateNext = SRun;
            SRun:    if (!ABus.ARun) stateNext = SIdle;
            default: stateNext = SIdle;
        endcase
    end

    // State register; it advances only on enabled cycles.
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            fState <= SIdle;
        end else if (ABus.AClkHEn) begin
            fState <= stateNext;
        end
    end

    // Phase step and counter update; the first event after arming starts from a zero phase.
    always_comb begin
        addend    = (fState == SArm) ? 16'h0000 : fAcc;
        phaseSum  = {1'b0, addend} + {1'b0, fInc};
        accActive = isEvent && ((fState == SArm) || (fState == SRun));
        tickNext  = accActive & phaseSum[16];
        accNext   = fAcc;
        if (fState == SIdle) begin
            accNext = 16'h0000;
        end else if (accActive) begin
            accNext = phaseSum[15:0];
        end
        cntNext = fCnt;
        ovfNext = 1'b0;
        if (ABus.AClrCnt) begin
            cntNext = '0;
        end else if (tickNext) begin
            cntNext = fCnt + CCntOne;
            ovfNext = &fCnt;
        end
    end

    // Datapath registers; an increment write takes effect only from the next event.
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            fAcc     <= 16'h0000;
            fInc     <= CIncReset;
            fCnt     <= '0;
            fTick    <= 1'b0;
            fOvf     <= 1'b0;
            fCapVld  <= 1'b0;
            fCapData <= '0;
        end else if (ABus.AClkHEn) begin
            fAcc    <= accNext;
            fCnt    <= cntNext;
            fTick   <= tickNext;
            fOvf    <= ovfNext;
            fCapVld <= ABus.ACapReq;
            if (ABus.AIncWr) begin
                fInc <= ABus.AIncData;
            end
            if (ABus.ACapReq) begin
                fCapData <= cntNext;
            end
        end
    end

    assign ABus.ATick    = fTick;
    assign ABus.AOvf     = fOvf;
    assign ABus.ACapVld  = fCapVld;
    assign ABus.ACapData = fCapData;
    assign ABus.AState   = fState;

endmodule
